nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two wide operands by time-multiplexing one 4-bit ripple-carry adder slice, one nibble per clock, from the least significant nibble upward.
- Holds the carry in a register between nibbles.
- Has a valid/ready handshake on the operand side and on the result side.
- Sits between a requester that supplies wide operands and any consumer of the (W+1)-bit sum. It trades latency for area versus a full-width adder.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range is 2 to 16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start_valid  input  1  requester presents a, b and cin.
- start_ready  output  1  block can accept operands; high only in IDLE.
- a  input  W  operand A; sampled on the start handshake.
- b  input  W  operand B; sampled on the start handshake.
- cin  input  1  carry-in; sampled on the start handshake.
- busy  output  1  high in RUN or DONE.
- result_valid  output  1  sum is valid; high only in DONE.
- result_ready  input  1  consumer accepts sum.
- sum  output  W+1  registered result; bit W is the final carry-out.

Behaviour:
- Reset: rst_n low at a rising edge forces:
  - state = IDLE, sum = 0, carry = 0, nibble counter = 0;
  - A/B shift registers = 0;
  - result_valid = 0, busy = 0.
  - start_ready is 0 while rst_n is low, then 1 from the first cycle after rst_n goes high.
- Reset mid-operation: the in-flight computation is discarded, with no partial result or valid pulse. Same end state as the reset above.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready: load a and b into shift registers, set carry <= cin, cnt <= 0, and go to RUN.
  - sum keeps its previous value.
- RUN:
  - Each cycle the slice computes {cout, s4} = a_sh[3:0] + b_sh[3:0] + carry.
  - Update: s4 is shifted into the top of the sum shift register; carry <= cout; a_sh and b_sh shift right by 4; cnt <= cnt + 1.
  - When cnt == NIBBLES-1: sum[W] <= cout, all W sum bits are in place, and the FSM goes to DONE.
  - start_valid is ignored.
- DONE:
  - result_valid = 1.
  - sum is stable, then remains held after DONE exits.
  - On result_ready go to IDLE.
  - With result_ready held low, stay in DONE indefinitely with sum unchanged.
- Latency:
  - The start handshake occurs at edge k.
  - RUN occupies edges k+1 to k+NIBBLES.
  - result_valid is first high in the cycle after edge k+NIBBLES.
  - With result_ready = 1 at that point, start_ready returns at edge k+NIBBLES+1. Minimum initiation interval is NIBBLES+2 cycles.
- Arithmetic:
  - Unsigned.
  - sum = a + b + cin exactly, with W+1 bits and no overflow possible.
  - Carry propagates between nibbles only through the carry register.
- Intermediate sum bits are not visible as valid. sum may change during RUN, and consumers must qualify it with result_valid.
- Counter: log2(NIBBLES) bits; it does not wrap in normal operation.
- Simultaneous events: a start_valid that coincides with result_valid/result_ready is not accepted in that cycle; it is taken on the next IDLE cycle.

Decomposition:
- Shared package contents:
  - NIBBLE_W = 4;
  - state encoding IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  - MAX_NIBBLES = 16.
- One sub-module, nibble_add: a purely combinational 4-bit ripple-carry slice with ports x[3:0], y[3:0], ci, s[3:0] and co, built from full-adder cells.
- The controller instantiates exactly one nibble_add. The FSM, shift registers, carry register and counter live in the top.

Test Plan (NIBBLES = 4):
- a=16'h1234, b=16'h4321, cin=0; result_ready tied high -> result_valid high exactly 4 cycles after the cycle following the handshake, sum=17'h05555, result_valid high for 1 cycle.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=17'h10000; this exercises carry through all four nibbles via the carry register.
- a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=17'h1FFFF. Then a=0, b=0, cin=0 -> sum=17'h00000, which checks that no stale carry remains.
- Result backpressure: result_ready held low for 5 cycles after result_valid rises -> sum constant, start_ready=0, busy=1, and a start_valid pulse during this window is ignored. After result_ready goes high, IDLE follows and the next operand set is accepted.
- rst_n driven low for 1 cycle during the 2nd RUN cycle of a=16'hABCD, b=16'h1111 -> next cycle: state IDLE, result_valid=0, sum=0, busy=0, and no result is ever produced. A subsequent a=16'h0F0F, b=16'h00F1, cin=0 gives sum=17'h01000.
- Randomized back-to-back requests with start_valid always high: every accepted pair yields sum == a+b+cin, and the handshake spacing is never less than 6 cycles.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants, state encoding and the full-adder cell used by the
// nibble-serial adder.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int MAX_NIBBLES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // One full-adder cell; returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
        return {co, s};
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand and result handshake bundle. The master modport is the
// requester/consumer side; the slave modport is the adder.
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         result_valid;
    logic         result_ready;
    logic [W:0]   sum;

    modport master (
        output start_valid, a, b, cin, result_ready,
        input  start_ready, busy, result_valid, sum
    );

    modport slave (
        input  start_valid, a, b, cin, result_ready,
        output start_ready, busy, result_valid, sum
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl_nibble_add.sv
// Purely combinational 4-bit ripple-carry slice built from full-adder cells.
module nibble_add
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);
    logic [NIBBLE_W:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign {c_s[i+1], s[i]} = full_add(x[i], y[i], c_s[i]);
    end

    assign co = c_s[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide unsigned adder that reuses one 4-bit slice, one nibble per clock,
// LSB nibble first, with the inter-nibble carry held in a register.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_serial_adder_ctrl_if.slave     bus
);
    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       sum_q, sum_d;
    logic             start_ready_q, start_ready_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;

    logic [NIBBLE_W-1:0] s4_s;
    logic                cout_s;

    nibble_add u_nibble_add (
        .x  (a_sh_q[NIBBLE_W-1:0]),
        .y  (b_sh_q[NIBBLE_W-1:0]),
        .ci (carry_q),
        .s  (s4_s),
        .co (cout_s)
    );

    // Next-state and datapath update; outputs are derived from the next state
    // so that they come straight off flops.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid && start_ready_q) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d           = {{NIBBLE_W{1'b0}}, a_sh_q[W-1:NIBBLE_W]};
                b_sh_d           = {{NIBBLE_W{1'b0}}, b_sh_q[W-1:NIBBLE_W]};
                sum_d[W-1:0]     = {s4_s, sum_q[W-1:NIBBLE_W]};
                carry_d          = cout_s;
                if (cnt_q == LAST_CNT) begin
                    // Counter parks on the last nibble rather than wrapping.
                    sum_d[W] = cout_s;
                    state_d  = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        start_ready_d  = (state_d == IDLE);
        busy_d         = (state_d == RUN) || (state_d == DONE);
        result_valid_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            a_sh_q         <= {W{1'b0}};
            b_sh_q         <= {W{1'b0}};
            carry_q        <= 1'b0;
            cnt_q          <= {CNT_W{1'b0}};
            sum_q          <= {(W+1){1'b0}};
            start_ready_q  <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_sh_q         <= a_sh_d;
            b_sh_q         <= b_sh_d;
            carry_q        <= carry_d;
            cnt_q          <= cnt_d;
            sum_q          <= sum_d;
            start_ready_q  <= start_ready_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.sum          = sum_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with NIBBLES = 4.
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    // Free-running edge counter used to measure handshake spacing.
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder_ctrl_if #(.NIBBLES(4)) bus ();

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci);
        int n;
        n = 0;
        bus.a           = a;
        bus.b           = b;
        bus.cin         = ci;
        @(negedge clk);
        while (bus.start_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("start_ready_wait", {31'd0, bus.start_ready}, 32'd1);
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1 bus.start_valid = 1'b0;
    endtask

    task automatic wait_rv(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (bus.result_valid !== 1'b1 && lat < 40);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [16:0] exp);
        int lat;
        start_op(a, b, ci);
        wait_rv(lat);
        chk({tag, "_latency"}, lat, 32'd4);
        chk({tag, "_sum"}, {15'd0, bus.sum}, {15'd0, exp});
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_rv_one_cycle"}, {31'd0, bus.result_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, bus.start_ready}, 32'd1);
    endtask

    initial begin
        int         lat;
        int         prev_hs;
        int         hs;
        int         n;
        logic       seen_rv;
        logic [16:0] held;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] rexp;

        rst_n            = 1'b0;
        bus.start_valid  = 1'b0;
        bus.a            = 16'h0000;
        bus.b            = 16'h0000;
        bus.cin          = 1'b0;
        bus.result_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk("rst_start_ready", {31'd0, bus.start_ready}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("rst_sum", {15'd0, bus.sum}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.start_ready}, 32'd1);

        run_op("basic", 16'h1234, 16'h4321, 1'b0, 17'h05555);
        run_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        run_op("all_ones_cin", 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
        run_op("zero_no_stale", 16'h0000, 16'h0000, 1'b0, 17'h00000);

        // Result backpressure with a stray start request in the window.
        bus.result_ready = 1'b0;
        start_op(16'hA5A5, 16'h5A5A, 1'b1);
        wait_rv(lat);
        chk("bp_latency", lat, 32'd4);
        chk("bp_sum", {15'd0, bus.sum}, 32'h0001_0000);
        held = bus.sum;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.a           = 16'h0001;
                bus.b           = 16'h0001;
                bus.start_valid = 1'b1;
            end else begin
                bus.start_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            chk("bp_sum_hold", {15'd0, bus.sum}, {15'd0, held});
            chk("bp_rv", {31'd0, bus.result_valid}, 32'd1);
            chk("bp_start_ready", {31'd0, bus.start_ready}, 32'd0);
            chk("bp_busy", {31'd0, bus.busy}, 32'd1);
        end
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", {31'd0, bus.start_ready}, 32'd1);
        chk("bp_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("bp_idle_rv", {31'd0, bus.result_valid}, 32'd0);
        run_op("after_bp", 16'h0003, 16'h0004, 1'b0, 17'h00007);

        // Reset during the second RUN cycle.
        start_op(16'hABCD, 16'h1111, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_rv", {31'd0, bus.result_valid}, 32'd0);
        chk("mid_rst_sum", {15'd0, bus.sum}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.start_ready}, 32'd0);
        rst_n   = 1'b1;
        seen_rv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                seen_rv = 1'b1;
            end
        end
        chk("mid_rst_no_result", {31'd0, seen_rv}, 32'd0);
        chk("mid_rst_ready_back", {31'd0, bus.start_ready}, 32'd1);
        run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 17'h01000);

        // Back-to-back requests with start_valid held high throughout.
        prev_hs = 0;
        for (int k = 0; k < 8; k++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            rexp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            bus.a           = ra;
            bus.b           = rb;
            bus.cin         = rc;
            bus.start_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (bus.start_ready !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_ready_wait", {31'd0, bus.start_ready}, 32'd1);
            hs = cyc;
            if (k > 0) begin
                chk("b2b_spacing_ge6", {31'd0, (hs - prev_hs) >= 6}, 32'd1);
            end
            prev_hs = hs;
            @(posedge clk);
            #1;
            wait_rv(lat);
            chk("b2b_latency", lat, 32'd4);
            chk("b2b_sum", {15'd0, bus.sum}, {15'd0, rexp});
        end
        bus.start_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
